raycast_load_sequencer: RTL and testbench
=========================================

Name: raycast_load_sequencer

Overview:
- Multi-cycle sub-controller that sits directly upstream of the CPU datapath's raycast register bank. It drives that bank's write port and the datapath memory-address controls.
- The main controller hands it one raycast-load instruction and waits on busy/done. The block then does one of two things:
  - loads the ray origin or ray direction from the register-file pair, or
  - fetches the five-word wall segment from memory at destination+0..4.
- It then waits a fixed settle time for the ray/segment intersection logic before reporting done.

Parameters:
- READ_LATENCY, 1: cycles from memory address presented to memory_read_data valid. Legal values are 1 and 2.
- SETTLE_CYCLES, 4: cycles to wait after the last raycast write before done. Legal range is 0..15.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle request from main controller; sampled only in IDLE
- mode  input  2  00 load origin, 01 load direction, 10 load segment, 11 reserved
- busy  output  1  high from the cycle after accepted start until done cycle inclusive
- done  output  1  one-cycle pulse when the load and settle are complete
- raycast_write_enable  output  1  write strobe to the raycast register bank
- raycast_write_select  output  4  raycast register slot select (0000 origin pair, 0010 direction pair, 0100..1000 segment words 4..8)
- memory_address_select  output  2  datapath memory address mux: 00 program counter, 10 destination+offset
- memory_offset  output  3  word offset added to destination register for segment fetch

Behaviour:
- Reset state (also the idle value of every output): IDLE; busy=0, done=0, raycast_write_enable=0, raycast_write_select=0000, memory_address_select=00, memory_offset=000; counters cleared.
- Reset asserted mid-operation: the next edge forces IDLE with all outputs at reset values. A partially loaded bank is left as is, and no done is issued.
- States: IDLE, PAIR, FETCH, SETTLE, DONE.
- IDLE:
  - start=1 with mode 00 or 01 goes to PAIR.
  - start=1 with mode 10 goes to FETCH; issue counter=0, capture counter=0.
  - start=1 with mode 11 goes directly to DONE, with no writes and no settle.
  - start=0 stays in IDLE.
- start asserted while busy is ignored; it is not queued.
- PAIR (one cycle):
  - raycast_write_enable=1; raycast_write_select=0000 for mode 00, 0010 for mode 01.
  - The datapath captures the destination/source pair on this edge.
  - Next state is SETTLE.
- FETCH:
  - Issue side: memory_address_select=10 throughout FETCH; memory_offset=issue counter (0..4).
  - Issue counter increments each cycle, saturates at 4, and holds the offset at 4 after the last issue.
  - Capture side: the word for offset k is valid READ_LATENCY cycles after offset k is presented.
  - In each such cycle: raycast_write_enable=1, raycast_write_select=4+k (0100..1000).
  - Exactly five writes occur, in order 4,5,6,7,8, on consecutive cycles.
  - The first write is READ_LATENCY cycles after FETCH entry. FETCH occupies 5+READ_LATENCY cycles in total.
  - Enable is 0 in FETCH cycles with no valid capture.
  - After the capture for slot 8, go to SETTLE.
- SETTLE:
  - All write/address outputs are at idle values.
  - Counter runs SETTLE_CYCLES cycles, then goes to DONE.
  - SETTLE_CYCLES=0 skips SETTLE; the last write cycle proceeds directly to DONE.
- DONE (one cycle): done=1, busy=1; next state is IDLE.
- A start arriving in the cycle after DONE (in IDLE) is accepted normally. Back-to-back loads are therefore spaced by one IDLE cycle minimum.
- Latency, start edge to done high:
  - mode 00/01: 2+SETTLE_CYCLES cycles.
  - mode 10: 1+5+READ_LATENCY+SETTLE_CYCLES cycles (defaults: 11).
- Outputs are registered. No combinational path from start/mode to any output.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0 and busy never asserts.
- mode=00 start pulse with defaults:
  - one cycle later, raycast_write_enable=1 with select=0000 for exactly one cycle;
  - done pulses 6 cycles after start;
  - repeat with mode=01 -> select=0010.
- mode=10 with READ_LATENCY=1, RAM model returning 16'hA000+address, destination=16'h0040:
  - offsets 0..4 presented with memory_address_select=10;
  - writes to selects 4..8 capture A040..A044 in order;
  - done pulses 11 cycles after start.
- READ_LATENCY=2, SETTLE_CYCLES=0, mode=10 -> five consecutive writes start 2 cycles into FETCH; done 8 cycles after start.
- start held high continuously during a mode=10 load -> no second load begins until after DONE; exactly five writes per accepted start.
- Reset asserted on the third write of a segment fetch -> next cycle all outputs 0, busy=0, no done pulse; a fresh mode=00 start then completes normally.

Source files
------------

// File: rtl/raycast_load_sequencer.sv
// Raycast-load sub-controller: drives the raycast register bank write port and
// the datapath memory-address controls for one load instruction at a time.
// Origin/direction loads write a register pair in a single cycle; segment
// loads fetch five words from destination+0..4 and write them to slots 4..8.
// Every load ends with a fixed settle window before a one-cycle done pulse.
// All outputs come straight from flops; the next output values are decoded
// from the next state so that outputs line up with the state they describe.
module raycast_load_sequencer #(
    parameter int READ_LATENCY  = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic       raycast_write_enable,
    output logic [3:0] raycast_write_select,
    output logic [1:0] memory_address_select,
    output logic [2:0] memory_offset
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAIR,
        S_FETCH,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_ORIGIN    = 2'b00;
    localparam logic [1:0] MODE_DIRECTION = 2'b01;
    localparam logic [1:0] MODE_SEGMENT   = 2'b10;

    localparam logic [3:0] SEL_ORIGIN     = 4'b0000;
    localparam logic [3:0] SEL_DIRECTION  = 4'b0010;
    localparam logic [3:0] SEL_SEG_BASE   = 4'b0100;

    localparam logic [1:0] ADDR_PC        = 2'b00;
    localparam logic [1:0] ADDR_DEST_OFS  = 2'b10;

    // FETCH cycle counter: offset k is presented in cycle k (saturating at 4),
    // and its word is captured in cycle k+READ_LATENCY. The last capture
    // (slot 8) lands in cycle 4+READ_LATENCY.
    localparam logic [2:0] RL_C        = 3'(READ_LATENCY);
    localparam logic [2:0] LAST_OFFSET = 3'd4;
    localparam logic [2:0] FETCH_LAST  = 3'(4 + READ_LATENCY);

    // A zero-length settle window bypasses SETTLE entirely.
    localparam bit         SKIP_SETTLE = (SETTLE_CYCLES == 0);
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [2:0] fetch_cnt_q, fetch_cnt_d;
    logic [3:0] settle_cnt_q, settle_cnt_d;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       we_q, we_d;
    logic [3:0] sel_q, sel_d;
    logic [1:0] addr_sel_q, addr_sel_d;
    logic [2:0] offset_q, offset_d;

    // Next-state and counter logic; start is only looked at in IDLE so a
    // request arriving while busy is dropped rather than queued.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        fetch_cnt_d  = fetch_cnt_q;
        settle_cnt_d = settle_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    unique case (mode)
                        MODE_ORIGIN, MODE_DIRECTION: state_d = S_PAIR;
                        MODE_SEGMENT: begin
                            state_d     = S_FETCH;
                            fetch_cnt_d = 3'd0;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end

            S_PAIR: begin
                settle_cnt_d = 4'd0;
                state_d      = SKIP_SETTLE ? S_DONE : S_SETTLE;
            end

            S_FETCH: begin
                if (fetch_cnt_q == FETCH_LAST) begin
                    settle_cnt_d = 4'd0;
                    state_d      = SKIP_SETTLE ? S_DONE : S_SETTLE;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + 3'd1;
                end
            end

            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_DONE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Decode the output values for the upcoming state so they can be
    // registered and appear in the same cycle as that state.
    always_comb begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        we_d       = 1'b0;
        sel_d      = SEL_ORIGIN;
        addr_sel_d = ADDR_PC;
        offset_d   = 3'd0;

        unique case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end

            S_PAIR: begin
                busy_d = 1'b1;
                we_d   = 1'b1;
                sel_d  = (mode_d == MODE_DIRECTION) ? SEL_DIRECTION : SEL_ORIGIN;
            end

            S_FETCH: begin
                busy_d     = 1'b1;
                addr_sel_d = ADDR_DEST_OFS;
                offset_d   = (fetch_cnt_d > LAST_OFFSET) ? LAST_OFFSET : fetch_cnt_d;
                if (fetch_cnt_d >= RL_C) begin
                    we_d  = 1'b1;
                    sel_d = SEL_SEG_BASE + {1'b0, fetch_cnt_d - RL_C};
                end
            end

            S_SETTLE: begin
                busy_d = 1'b1;
            end

            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end

            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset returns everything to the
    // idle values and abandons any load in progress without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_ORIGIN;
            fetch_cnt_q  <= 3'd0;
            settle_cnt_q <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= SEL_ORIGIN;
            addr_sel_q   <= ADDR_PC;
            offset_q     <= 3'd0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            fetch_cnt_q  <= fetch_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            addr_sel_q   <= addr_sel_d;
            offset_q     <= offset_d;
        end
    end

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign raycast_write_enable  = we_q;
    assign raycast_write_select  = sel_q;
    assign memory_address_select = addr_sel_q;
    assign memory_offset         = offset_q;

endmodule

// File: tb/tb_raycast_load_sequencer.sv
// Directed bench for raycast_load_sequencer: one instance with the default
// timing (READ_LATENCY=1, SETTLE_CYCLES=4) and one with READ_LATENCY=2,
// SETTLE_CYCLES=0, plus a small RAM/address-mux model of the datapath.
module tb_raycast_load_sequencer;

    localparam logic [15:0] DEST = 16'h0040;
    localparam logic [15:0] PC   = 16'h1000;

    logic clk;
    logic rst;

    logic       a_start, a_busy, a_done, a_we;
    logic [1:0] a_mode, a_mas;
    logic [3:0] a_sel;
    logic [2:0] a_off;

    logic       b_start, b_busy, b_done, b_we;
    logic [1:0] b_mode, b_mas;
    logic [3:0] b_sel;
    logic [2:0] b_off;

    int n_tests = 0;
    int n_fail  = 0;
    int writes  = 0;

    raycast_load_sequencer #(.READ_LATENCY(1), .SETTLE_CYCLES(4)) dut_a (
        .clock                 (clk),
        .reset                 (rst),
        .start                 (a_start),
        .mode                  (a_mode),
        .busy                  (a_busy),
        .done                  (a_done),
        .raycast_write_enable  (a_we),
        .raycast_write_select  (a_sel),
        .memory_address_select (a_mas),
        .memory_offset         (a_off)
    );

    raycast_load_sequencer #(.READ_LATENCY(2), .SETTLE_CYCLES(0)) dut_b (
        .clock                 (clk),
        .reset                 (rst),
        .start                 (b_start),
        .mode                  (b_mode),
        .busy                  (b_busy),
        .done                  (b_done),
        .raycast_write_enable  (b_we),
        .raycast_write_select  (b_sel),
        .memory_address_select (b_mas),
        .memory_offset         (b_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath address mux and RAM returning 16'hA000 + address.
    logic [15:0] addr_a, addr_b, rd_a, rd_b1, rd_b2;
    assign addr_a = (a_mas == 2'b10) ? DEST + {13'b0, a_off} : PC;
    assign addr_b = (b_mas == 2'b10) ? DEST + {13'b0, b_off} : PC;

    always @(posedge clk) begin
        rd_a  <= 16'hA000 + addr_a;
        rd_b1 <= 16'hA000 + addr_b;
        rd_b2 <= rd_b1;
    end

    logic [11:0] a_vec, b_vec;
    assign a_vec = {a_busy, a_done, a_we, a_sel, a_mas, a_off};
    assign b_vec = {b_busy, b_done, b_we, b_sel, b_mas, b_off};

    function automatic logic [11:0] ev(input logic busy, input logic done, input logic we,
                                       input logic [3:0] sel, input logic [1:0] mas,
                                       input logic [2:0] off);
        return {busy, done, we, sel, mas, off};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Origin/direction load on instance A: write one cycle after start,
    // four settle cycles, done six cycles after start.
    task automatic pair_load_a(input logic [1:0] m, input logic [3:0] sel, input string tag);
        @(negedge clk); a_mode = m; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        chk({tag, "_write"}, a_vec, ev(1, 0, 1, sel, 2'b00, 3'd0));
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            chk({tag, "_settle"}, a_vec, ev(1, 0, 0, 4'd0, 2'b00, 3'd0));
        end
        @(negedge clk);
        chk({tag, "_done"}, a_vec, ev(1, 1, 0, 4'd0, 2'b00, 3'd0));
        @(negedge clk);
        chk({tag, "_idle"}, a_vec, 12'h000);
    endtask

    initial begin
        logic [2:0] off_exp;
        rst = 1'b1;
        a_start = 1'b0; a_mode = 2'b00;
        b_start = 1'b0; b_mode = 2'b00;

        // Reset and idle.
        repeat (3) @(negedge clk);
        chk("reset_a", a_vec, 12'h000);
        chk("reset_b", b_vec, 12'h000);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_a", a_vec, 12'h000);
            chk("idle_b", b_vec, 12'h000);
        end

        // Pair loads.
        pair_load_a(2'b00, 4'b0000, "origin");
        pair_load_a(2'b01, 4'b0010, "direction");

        // Segment load, READ_LATENCY=1, SETTLE_CYCLES=4.
        @(negedge clk); a_mode = 2'b10; a_start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); a_start = 1'b0;
            off_exp = (k - 1 > 4) ? 3'd4 : 3'(k - 1);
            if (k >= 2) begin
                chk("seg1_fetch", a_vec, ev(1, 0, 1, 4'(4 + k - 2), 2'b10, off_exp));
                chk("seg1_data", rd_a, 16'hA040 + 16'(k - 2));
            end else begin
                chk("seg1_fetch", a_vec, ev(1, 0, 0, 4'd0, 2'b10, off_exp));
            end
        end
        for (int k = 7; k <= 10; k++) begin
            @(negedge clk);
            chk("seg1_settle", a_vec, ev(1, 0, 0, 4'd0, 2'b00, 3'd0));
        end
        @(negedge clk);
        chk("seg1_done", a_vec, ev(1, 1, 0, 4'd0, 2'b00, 3'd0));
        @(negedge clk);
        chk("seg1_idle", a_vec, 12'h000);

        // Reserved mode: straight to done.
        @(negedge clk); a_mode = 2'b11; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        chk("reserved_done", a_vec, ev(1, 1, 0, 4'd0, 2'b00, 3'd0));
        @(negedge clk);
        chk("reserved_idle", a_vec, 12'h000);

        // Segment load, READ_LATENCY=2, SETTLE_CYCLES=0.
        @(negedge clk); b_mode = 2'b10; b_start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); b_start = 1'b0;
            off_exp = (k - 1 > 4) ? 3'd4 : 3'(k - 1);
            if (k >= 3) begin
                chk("seg2_fetch", b_vec, ev(1, 0, 1, 4'(4 + k - 3), 2'b10, off_exp));
                chk("seg2_data", rd_b2, 16'hA040 + 16'(k - 3));
            end else begin
                chk("seg2_fetch", b_vec, ev(1, 0, 0, 4'd0, 2'b10, off_exp));
            end
        end
        @(negedge clk);
        chk("seg2_done", b_vec, ev(1, 1, 0, 4'd0, 2'b00, 3'd0));
        @(negedge clk);
        chk("seg2_idle", b_vec, 12'h000);

        // Pair load with no settle window: done two cycles after start.
        @(negedge clk); b_mode = 2'b01; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        chk("pair_nosettle_write", b_vec, ev(1, 0, 1, 4'b0010, 2'b00, 3'd0));
        @(negedge clk);
        chk("pair_nosettle_done", b_vec, ev(1, 1, 0, 4'd0, 2'b00, 3'd0));

        // Start held high through a segment load: ignored while busy,
        // accepted again in the IDLE cycle after DONE.
        @(negedge clk); a_mode = 2'b10; a_start = 1'b1;
        writes = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (a_we) writes++;
        end
        chk("held_done", a_vec, ev(1, 1, 0, 4'd0, 2'b00, 3'd0));
        chk("held_writes1", writes, 5);
        @(negedge clk);
        chk("held_gap_idle", a_vec, 12'h000);
        @(negedge clk); a_start = 1'b0;
        chk("held_restart", a_vec, ev(1, 0, 0, 4'd0, 2'b10, 3'd0));
        writes = 0;
        for (int k = 14; k <= 23; k++) begin
            @(negedge clk);
            if (a_we) writes++;
        end
        chk("held_done2", a_vec, ev(1, 1, 0, 4'd0, 2'b00, 3'd0));
        chk("held_writes2", writes, 5);
        @(negedge clk);
        chk("held_idle2", a_vec, 12'h000);

        // Reset on the third write of a segment fetch.
        @(negedge clk); a_mode = 2'b10; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_third_write", a_vec, ev(1, 0, 1, 4'd6, 2'b10, 3'd3));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_reset", a_vec, 12'h000);
        rst = 1'b0;
        writes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_busy || a_done || a_we) writes++;
        end
        chk("abort_no_activity", writes, 0);
        pair_load_a(2'b00, 4'b0000, "after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
